pwm_compare_stage: RTL
======================

// Module: pwm_compare_stage
// PURPOSE
//  Downstream consumer of a free-running modulo-MAX up counter (count value Q, 0..MAX-1).
//  Compares the incoming count against a duty value and drives a PWM output with a 1-cycle registered latency.
//  Duty updates use a valid/ready handshake into a shadow register, applied only on counter wrap (glitch-free period).
//  Also emits a 1-cycle WRAP strobe.
// PARAMETERS
//  WIDTH     4   count width; matches the upstream counter output width
//  MAX       16  counter modulus; counter runs 0..MAX-1; MAX <= 2**WIDTH
//  DEADTIME  2   dead-time in C cycles; used only with PWM_COMPL_EN; range 1..15
// PORTS
//  C         in   1        clock, rising edge
//  CLR       in   1        synchronous reset, active-high
//  CNT       in   WIDTH    count value from the upstream modulo counter
//  DUTY      in   WIDTH+1  requested high-time in counts (0..MAX)
//  DUTY_VLD  in   1        DUTY valid
//  DUTY_RDY  out  1        shadow register empty; transfer occurs when DUTY_VLD & DUTY_RDY at a rising edge of C
//  PWM       out  1        PWM output, registered
//  WRAP      out  1        1-cycle pulse; CNT has wrapped
//  PWM_N     out  1        complementary output; port present only with PWM_COMPL_EN
// BEHAVIOUR
//  Reset
//   - One clock, C. CLR is synchronous, active-high; it is sampled only on the rising edge of C.
//   - CLR sets: PWM=0, WRAP=0, PWM_N=0, active duty=0, shadow empty, prev_cnt=0.
//   - DUTY_RDY=1 from the first cycle after CLR deasserts. DUTY_RDY is combinational from ~shadow_full.
//   - CLR asserted mid-period discards any pending shadow value.
//  Wrap detection
//   - prev_cnt <= CNT every cycle. wrap_raw = (CNT < prev_cnt).
//   - WRAP <= wrap_raw (registered, 1-cycle pulse).
//   - No false wrap is possible after reset, because prev_cnt=0.
//  Duty handshake
//   - On accept: shadow <= min(DUTY, MAX) (saturate) and shadow_full <= 1.
//   - While shadow_full=1, DUTY_RDY=0.
//   - On wrap_raw & shadow_full: active <= shadow and shadow_full <= 0. This takes effect for the compare on the same cycle's CNT (the first count of the new period).
//   - Accept and wrap_raw in the same cycle (shadow empty): the value goes to the shadow only. It applies at the next wrap and is never lost.
//  Compare
//   - PWM <= (CNT < active_eff), where active_eff is the duty in force for this CNT.
//   - Latency: 1 cycle from CNT to PWM.
//   - Duty 0 -> PWM constant 0. Duty MAX -> PWM constant 1. Duty k -> high for k of every MAX cycles.
//   - Arithmetic is done at WIDTH+1 bits unsigned; CNT is zero-extended.
//   - CNT values >= MAX (upstream fault) are compared as-is; no error flag is raised.
// CONFIGURATION
//  Macro: PWM_COMPL_EN
//  - Defined: PWM_N port exists.
//    - On every edge of the raw compare bit, a dead-time counter is loaded with DEADTIME.
//    - PWM = raw & (dt==0). PWM_N = ~raw & (dt==0).
//    - Both outputs are never high in the same cycle.
//    - If raw toggles during dead-time, the counter reloads.
//    - Reset loads dt=DEADTIME, so both outputs stay low for DEADTIME cycles after reset.
//    - Duty 0 or MAX -> the constant output appears after DEADTIME cycles; the other output stays low.
//  - Undefined: no PWM_N port and no dead-time logic; PWM = raw compare register.
// STRUCTURE
//  - Package pwm_pkg: localparams for WIDTH+1 duty width and the saturation constant MAX; dead-time counter width (4 bits).
//  - Sub-module pwm_deadtime (raw in, PWM/PWM_N out, DEADTIME parameter).
//    - Instantiated only under PWM_COMPL_EN.
//    - Everything else is flat in pwm_compare_stage.
// TESTING
//  - Reset: hold CLR for 3 cycles with CNT running -> PWM=0, WRAP=0, DUTY_RDY=1 on the first cycle after release.
//  - Basic: load DUTY=4, CNT free-running 0..15 -> after the first wrap, PWM high exactly 4 of every 16 cycles, 1 cycle after CNT=0..3.
//  - Shadow: load DUTY=12 mid-period while DUTY=4 is active
//    -> DUTY_RDY low until the wrap; the current period stays at 4 high; the next period is 12 high.
//  - Extremes/saturation:
//    - DUTY=0 -> PWM never high.
//    - DUTY=16 -> PWM constant 1.
//    - DUTY=31 -> saturates to 16, PWM constant 1.
//  - Simultaneous: DUTY_VLD asserted on the CNT 15->0 cycle -> WRAP pulses; the new duty applies at the following wrap, not this one.
//  - PWM_COMPL_EN, DEADTIME=2, DUTY=8 -> PWM and PWM_N never both 1; a 2-cycle both-low gap at each transition.
//    Mid-period CLR -> both low for 2 cycles.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants for the PWM compare stage: default geometry, duty width and dead-time counter width.
// The complementary-output option is selected by the PWM_COMPL_EN macro in pwm_compare_stage.
package pwm_pkg;

    localparam int PWM_WIDTH    = 4;
    localparam int PWM_MAX      = 16;
    localparam int PWM_DEADTIME = 2;

    // Duty is one bit wider than the count so that "always high" (duty == MAX) is representable.
    localparam int DUTY_WIDTH   = PWM_WIDTH + 1;
    localparam int DT_WIDTH     = 4;

endpackage

// File: rtl/pwm_deadtime.sv
// Dead-time insertion between the raw compare bit and a complementary PWM/PWM_N pair.
// Used by pwm_compare_stage only when PWM_COMPL_EN is defined.
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int DEADTIME = PWM_DEADTIME
) (
    input  logic clk,
    input  logic clr,
    input  logic raw_in,
    output logic pwm,
    output logic pwm_n
);

    localparam logic [DT_WIDTH-1:0] DT_LOAD = DT_WIDTH'(DEADTIME);
    localparam logic [DT_WIDTH-1:0] DT_ZERO = {DT_WIDTH{1'b0}};
    localparam logic [DT_WIDTH-1:0] DT_ONE  = {{(DT_WIDTH-1){1'b0}}, 1'b1};

    logic                raw_q;
    logic                raw_d;
    logic [DT_WIDTH-1:0] dt_q;
    logic [DT_WIDTH-1:0] dt_d;
    logic                pwm_q;
    logic                pwm_d;
    logic                pwm_n_q;
    logic                pwm_n_d;
    logic                settled_s;

    // Reload the dead-time counter on every raw edge; outputs are computed from the next count so they stay registered.
    always_comb begin
        raw_d = raw_in;
        if (raw_in != raw_q) begin
            dt_d = DT_LOAD;
        end else if (dt_q != DT_ZERO) begin
            dt_d = dt_q - DT_ONE;
        end else begin
            dt_d = dt_q;
        end
        settled_s = (dt_d == DT_ZERO);
        pwm_d     = raw_in & settled_s;
        pwm_n_d   = ~raw_in & settled_s;
    end

    // State and output registers; reset behaves like a fresh edge so both outputs stay low for DEADTIME cycles.
    always_ff @(posedge clk) begin
        if (clr) begin
            raw_q   <= 1'b0;
            dt_q    <= DT_LOAD;
            pwm_q   <= 1'b0;
            pwm_n_q <= 1'b0;
        end else begin
            raw_q   <= raw_d;
            dt_q    <= dt_d;
            pwm_q   <= pwm_d;
            pwm_n_q <= pwm_n_d;
        end
    end

    assign pwm   = pwm_q;
    assign pwm_n = pwm_n_q;

endmodule

// File: rtl/pwm_compare_stage.sv
// PWM compare stage fed by a free-running modulo-MAX counter: wrap strobe, shadowed duty handshake, registered PWM.
// Define PWM_COMPL_EN to add the PWM_N output with dead-time insertion (pwm_deadtime).
module pwm_compare_stage
    import pwm_pkg::*;
#(
    parameter int WIDTH    = PWM_WIDTH,
    parameter int MAX      = PWM_MAX,
    parameter int DEADTIME = PWM_DEADTIME
) (
    input  logic             C,
    input  logic             CLR,
    input  logic [WIDTH-1:0] CNT,
    input  logic [WIDTH:0]   DUTY,
    input  logic             DUTY_VLD,
    output logic             DUTY_RDY,
    output logic             PWM,
`ifdef PWM_COMPL_EN
    output logic             PWM_N,
`endif
    output logic             WRAP
);

    localparam logic [WIDTH:0] MAX_D = (WIDTH+1)'(MAX);

    logic [WIDTH-1:0] prev_cnt_q;
    logic [WIDTH-1:0] prev_cnt_d;
    logic [WIDTH:0]   shadow_q;
    logic [WIDTH:0]   shadow_d;
    logic             shadow_full_q;
    logic             shadow_full_d;
    logic [WIDTH:0]   active_q;
    logic [WIDTH:0]   active_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             raw_d;

    logic             wrap_raw_s;
    logic             accept_s;
    logic [WIDTH:0]   duty_sat_s;
    logic [WIDTH:0]   active_eff_s;

    // Wrap detection, duty handshake and compare for the count presented this cycle.
    always_comb begin
        wrap_raw_s    = (CNT < prev_cnt_q);
        accept_s      = DUTY_VLD & ~shadow_full_q;
        duty_sat_s    = (DUTY > MAX_D) ? MAX_D : DUTY;

        prev_cnt_d    = CNT;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        active_d      = active_q;
        active_eff_s  = active_q;

        // A pending value is promoted on the wrap cycle itself so the first count of the new period already uses it.
        // Accept needs an empty shadow and promotion needs a full one, so the two never collide.
        if (wrap_raw_s && shadow_full_q) begin
            active_d      = shadow_q;
            active_eff_s  = shadow_q;
            shadow_full_d = 1'b0;
        end else if (accept_s) begin
            shadow_d      = duty_sat_s;
            shadow_full_d = 1'b1;
        end else begin
            shadow_full_d = shadow_full_q;
        end

        wrap_d = wrap_raw_s;
        raw_d  = ({1'b0, CNT} < active_eff_s);
    end

    // Core state registers.
    always_ff @(posedge C) begin
        if (CLR) begin
            prev_cnt_q    <= {WIDTH{1'b0}};
            shadow_q      <= {(WIDTH+1){1'b0}};
            shadow_full_q <= 1'b0;
            active_q      <= {(WIDTH+1){1'b0}};
            wrap_q        <= 1'b0;
        end else begin
            prev_cnt_q    <= prev_cnt_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            active_q      <= active_d;
            wrap_q        <= wrap_d;
        end
    end

    assign DUTY_RDY = ~shadow_full_q;
    assign WRAP     = wrap_q;

`ifdef PWM_COMPL_EN
    pwm_deadtime #(
        .DEADTIME (DEADTIME)
    ) u_deadtime (
        .clk    (C),
        .clr    (CLR),
        .raw_in (raw_d),
        .pwm    (PWM),
        .pwm_n  (PWM_N)
    );
`else
    logic raw_q;

    // Registered compare bit drives PWM directly.
    always_ff @(posedge C) begin
        if (CLR) begin
            raw_q <= 1'b0;
        end else begin
            raw_q <= raw_d;
        end
    end

    assign PWM = raw_q;
`endif

endmodule
